// File: rtl/mem_arbiter_if.sv
// Request/grant bus between the two memory requesters, the shared memory and mem_arbiter.
// slave is the arbiter side; master is the side that drives requests and memory read data.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              lock0;
  logic              lock1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wd, mem_we
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single unified memory, with bounded burst locking.
// Define MEM_ARB_STATS_EN to add saturating grant/contention counters.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]   grant_cnt0,
  output logic [31:0]   grant_cnt1,
  output logic [31:0]   contention_cnt
`endif
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  logic              last_grant_q, last_grant_d;
  logic              owner_valid_q, owner_valid_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic win1;
  logic any_gnt;
  logic owner_lock;

  always_comb begin
    owner_lock = last_grant_q ? bus.lock1 : bus.lock0;
    if (bus.req0 && bus.req1) begin
      // Previous owner keeps the bus only while it asks to and is under the hold limit.
      if (owner_valid_q && owner_lock && (hold_cnt_q < HoldMax)) begin
        win1 = last_grant_q;
      end else begin
        win1 = ~last_grant_q;
      end
    end else begin
      win1 = bus.req1;
    end
    any_gnt = (bus.req0 | bus.req1) & ~reset;

    bus.gnt0     = any_gnt & ~win1;
    bus.gnt1     = any_gnt & win1;
    bus.mem_addr = '0;
    bus.mem_wd   = '0;
    bus.mem_we   = 1'b0;
    if (any_gnt) begin
      bus.mem_addr = win1 ? bus.addr1 : bus.addr0;
      bus.mem_wd   = win1 ? bus.wdata1 : bus.wdata0;
      bus.mem_we   = win1 ? bus.we1 : bus.we0;
    end
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    owner_valid_d = 1'b0;
    hold_cnt_d    = '0;
    if (any_gnt) begin
      last_grant_d  = win1;
      owner_valid_d = win1 ? bus.lock1 : bus.lock0;
      if ((win1 == last_grant_q) && (win1 ? bus.req0 : bus.req1)) begin
        hold_cnt_d = (hold_cnt_q < HoldMax) ? hold_cnt_q + 1'b1 : hold_cnt_q;
      end
    end
    rvalid0_d = bus.gnt0 & ~bus.we0;
    rvalid1_d = bus.gnt1 & ~bus.we1;
    rdata_d   = (rvalid0_d | rvalid1_d) ? bus.mem_rd : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= 1'b1;
      owner_valid_q <= 1'b0;
      hold_cnt_q    <= '0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata_q       <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      owner_valid_q <= owner_valid_d;
      hold_cnt_q    <= hold_cnt_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata_q       <= rdata_d;
    end
  end

  // A read return still pending when reset rises is dropped immediately.
  assign bus.rvalid0 = rvalid0_q & ~reset;
  assign bus.rvalid1 = rvalid1_q & ~reset;
  assign bus.rdata   = rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] grant_cnt0_q, grant_cnt0_d;
  logic [31:0] grant_cnt1_q, grant_cnt1_d;
  logic [31:0] contention_cnt_q, contention_cnt_d;

  always_comb begin
    grant_cnt0_d     = grant_cnt0_q;
    grant_cnt1_d     = grant_cnt1_q;
    contention_cnt_d = contention_cnt_q;
    if (bus.gnt0 && (grant_cnt0_q != '1)) grant_cnt0_d = grant_cnt0_q + 32'd1;
    if (bus.gnt1 && (grant_cnt1_q != '1)) grant_cnt1_d = grant_cnt1_q + 32'd1;
    if (bus.req0 && bus.req1 && (contention_cnt_q != '1)) begin
      contention_cnt_d = contention_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0_q     <= '0;
      grant_cnt1_q     <= '0;
      contention_cnt_q <= '0;
    end else begin
      grant_cnt0_q     <= grant_cnt0_d;
      grant_cnt1_q     <= grant_cnt1_d;
      contention_cnt_q <= contention_cnt_d;
    end
  end

  assign grant_cnt0     = grant_cnt0_q;
  assign grant_cnt1     = grant_cnt1_q;
  assign contention_cnt = contention_cnt_q;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters.
- Port 0 is the multicycle core (fetch and load/store); port 1 is a loader/debug DMA that fills or inspects memory while the core runs.
- Grant is decided in the same cycle as the request; read data returns registered one cycle later.
- Contention resolves by round-robin, with an optional bounded lock for bursts.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- MAX_HOLD, 4, maximum consecutive locked grants to one port while the other port waits (must be ≥ 1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- req0 / req1  input  1  transfer request, ports 0 and 1
- lock0 / lock1  input  1  request to retain ownership on the next beat (burst)
- we0 / we1  input  1  1 = write, 0 = read
- addr0 / addr1  input  ADDR_W  byte address
- wdata0 / wdata1  input  DATA_W  write data
- gnt0 / gnt1  output  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  output  1  read data valid; asserted the cycle after a granted read
- rdata  output  DATA_W  registered read data, shared by both ports and qualified by rvalidN
- mem_addr  output  ADDR_W  to memory A
- mem_wd  output  DATA_W  to memory WD
- mem_we  output  1  to memory WE
- mem_rd  input  DATA_W  from memory RD (combinational read)

Behaviour:
- Clocking: all state updates on the posedge of clk. reset is synchronous, active-high, and overrides everything.
- Reset values:
  - gnt0 = gnt1 = 0 while reset is high.
  - rvalid0 = rvalid1 = 0, rdata = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - hold_cnt = 0, owner_valid = 0.
- Handshake:
  - A requester holds reqN, weN, addrN and wdataN stable until it samples gntN = 1 at a posedge.
  - One transfer is performed per grant cycle. Back-to-back grants are allowed.
- Winner selection (combinational, each cycle):
  - Neither request: no grant. mem_addr = 0, mem_wd = 0, mem_we = 0.
  - Exactly one request: that port wins.
  - Both requests, lock case: the previous-cycle winner keeps the grant if owner_valid = 1, its lockN = 1 and hold_cnt < MAX_HOLD.
  - Both requests, otherwise: the port ≠ last_grant wins (round-robin).
- Memory drive:
  - mem_addr = addr of the winner; mem_wd = wdata of the winner.
  - mem_we = weN & gntN of the winner. mem_we is never high without a grant.
- Sequential updates on a grant cycle:
  - last_grant = winner; owner_valid = winner's lockN.
  - hold_cnt: increments (saturating at MAX_HOLD) if the winner equals the previous winner and the other port was requesting; otherwise it resets to 0.
- No-grant cycle: owner_valid = 0 and hold_cnt = 0.
- Read return:
  - On a granted read, rdata <= mem_rd and rvalidN = 1 for exactly one cycle after the grant.
  - A granted write produces no rvalid, and rdata holds its value.
- Starvation bound: a waiting requester is granted within MAX_HOLD + 1 cycles of raising its request.
- Boundary conditions:
  - Lock released mid-burst: the other port wins on the next contention.
  - lockN high with no contention: no limit on ownership; hold_cnt stays 0.
  - Reset mid-transfer: a pending rvalid is dropped, and the in-flight write completes only if the grant cycle preceded the reset edge.
  - Simultaneous read on one port and write on the other: they serialise; no combining.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds the following 32-bit outputs, all reset to 0 and saturating at 0xFFFFFFFF:
  - grant_cnt0 and grant_cnt1: count grant cycles per port.
  - contention_cnt: counts cycles where req0 & req1.
- When not defined, these ports and counters do not exist, and arbitration behaviour is identical.

Test Plan:
- Reset, then req0 = 1, we0 = 0, addr0 = 0x10 with mem_rd = 0xDEADBEEF → gnt0 = 1 the same cycle; next cycle rvalid0 = 1 and rdata = 0xDEADBEEF; rvalid1 = 0.
- req0 = req1 = 1 with no lock, held for 4 cycles → grants alternate 0, 1, 0, 1 (port 0 first after reset).
- Port 1 write: we1 = 1, addr1 = 0x20, wdata1 = 0x12345678 → mem_we = 1, mem_addr = 0x20, mem_wd = 0x12345678 for one cycle; no rvalid1.
- Both requesting, lock1 = 1 continuously, MAX_HOLD = 4 → once port 1 wins the tie, it holds 5 consecutive grants (the initial grant plus 4 locked re-grants), then gnt0 = 1; port 0 wait ≤ 5 cycles.
- Granted read on port 1, with reset asserted the next cycle → rvalid1 = 0 and rdata = 0; after reset, a tie grants port 0.
- MEM_ARB_STATS_EN: 3 contention cycles plus 2 solo port-0 grants → contention_cnt = 3, grant_cnt0 = 4, grant_cnt1 = 1.
